// File: rtl/imem_pipelined.sv
// imem_pipelined: synchronous-read instruction memory with valid/ready request and response.
// Optional macro IMEM_FLUSH_EN adds a synchronous Flush input for branch redirect.
module imem_pipelined #(
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter int                    LATENCY    = 1,
  parameter string                 INIT_FILE  = "instruction_memory.mem",
  parameter logic [DATA_WIDTH-1:0] NOP_WORD   = '0
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  ReqValid,
  output logic                  ReqReady,
  input  logic [31:0]           ReqAddr,
  output logic                  RespValid,
  input  logic                  RespReady,
  output logic [DATA_WIDTH-1:0] RespInstr,
  output logic [31:0]           RespAddr,
  output logic                  RespErr
`ifdef IMEM_FLUSH_EN
  ,
  input  logic                  Flush
`endif
);

  localparam int AW = $clog2(DEPTH);
  localparam int FD = LATENCY + 1;
  localparam int PW = $clog2(FD);
  localparam int CW = $clog2(FD + 1);
  localparam int OW = $clog2(LATENCY + 2);

  typedef struct packed {
    logic                  err;
    logic [31:0]           addr;
    logic [DATA_WIDTH-1:0] data;
  } ent_t;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic flush;
`ifdef IMEM_FLUSH_EN
  assign flush = Flush;
`else
  assign flush = 1'b0;
`endif

  logic [OW-1:0] occ;
  logic          acc;
  logic          pop;
  logic          push;
  logic          mis;
  logic          oor;
  logic [AW-1:0] idx;
  logic          in_v;
  ent_t          in_e;
  logic          tail_v;
  ent_t          tail_e;

  assign ReqReady = (occ < OW'(LATENCY + 1)) && !flush;
  assign acc      = ReqValid && ReqReady;
  assign pop      = RespValid && RespReady;

  assign mis = |ReqAddr[1:0];
  assign oor = ReqAddr >= 32'(DEPTH * 4);
  assign idx = ReqAddr[AW+1:2];

  // Faulting fetches never touch the array; they carry NOP_WORD instead.
  always_comb begin
    in_v      = acc;
    in_e.err  = mis || oor;
    in_e.addr = ReqAddr;
    in_e.data = NOP_WORD;
    if (!(mis || oor)) in_e.data = mem[idx];
  end

  generate
    if (LATENCY == 1) begin : g_direct
      assign tail_v = in_v;
      assign tail_e = in_e;
    end else begin : g_pipe
      logic [LATENCY-2:0] pv;
      ent_t               pe [LATENCY-1];

      always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
          pv <= '0;
        end else if (flush) begin
          pv <= '0;
        end else begin
          pv[0] <= in_v;
          for (int i = 1; i < LATENCY - 1; i++) begin
            pv[i] <= pv[i-1];
          end
        end
      end

      always_ff @(posedge Clk) begin
        pe[0] <= in_e;
        for (int i = 1; i < LATENCY - 1; i++) begin
          pe[i] <= pe[i-1];
        end
      end

      assign tail_v = pv[LATENCY-2];
      assign tail_e = pe[LATENCY-2];
    end
  endgenerate

  assign push = tail_v && !flush;

  ent_t          fq [FD];
  logic [PW-1:0] rptr;
  logic [PW-1:0] wptr;
  logic [PW-1:0] hsel;
  logic [CW-1:0] fcnt;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(FD - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic logic [PW-1:0] prv(input logic [PW-1:0] p);
    return (p == '0) ? PW'(FD - 1) : p - 1'b1;
  endfunction

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      rptr <= '0;
      wptr <= '0;
      fcnt <= '0;
      for (int i = 0; i < FD; i++) begin
        fq[i] <= '0;
      end
    end else if (flush) begin
      fcnt <= '0;
      wptr <= rptr;
    end else begin
      if (push) begin
        fq[wptr] <= tail_e;
        wptr     <= nxt(wptr);
      end
      if (pop) rptr <= nxt(rptr);
      case ({push, pop})
        2'b10:   fcnt <= fcnt + 1'b1;
        2'b01:   fcnt <= fcnt - 1'b1;
        default: fcnt <= fcnt;
      endcase
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      occ <= '0;
    end else if (flush) begin
      occ <= '0;
    end else begin
      case ({acc, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // When empty, point at the slot just popped so the outputs hold.
  assign hsel      = (fcnt == '0) ? prv(rptr) : rptr;
  assign RespValid = (fcnt != '0);
  assign RespInstr = fq[hsel].data;
  assign RespAddr  = fq[hsel].addr;
  assign RespErr   = fq[hsel].err;

endmodule
